uart_tx_scheduler: RTL

Shares the single UART transmitter between two byte sources: keyboard ASCII output and VT100 parser reply strings (e.g. cursor-position reports `ESC [ r ; c R`).
- Each source has its own small FIFO.
- A round-robin scheduler drains the FIFOs into the transmitter using its start/busy handshake.
- Sits between the keyboard/parser and the UART transmitter, in the system clock domain.

---
 rtl/uart_tx_scheduler_pkg.sv | 19 +
 rtl/uart_tx_scheduler_fifo.sv | 55 +++++
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types for the UART transmit scheduler: source ids, FSM states, byte type.
// Pure declarations; no logic, no latency.
package uart_tx_scheduler_pkg;

  typedef enum logic {
    KEYBOARD = 1'b0,
    REPLY    = 1'b1
  } TxSource_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } TxSchedState_t;

  typedef logic [7:0] UartByte_t;

endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// Registered byte FIFO; a push is visible one edge later, push+pop on one edge both honoured.
// Push while full without a simultaneous pop is discarded; the caller decides what that means.
module byte_fifo
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  UartByte_t                wdata_i,
  input  logic                     pop_i,
  output UartByte_t                rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  UartByte_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot on the same edge, so a full FIFO still takes a push then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter between keyboard bytes and parser replies.
// Queued byte reaches txStart two cycles after its push; reply source is throttled by replyReady.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kbValid,
  input  logic [7:0]  kbData,
  input  logic        replyValid,
  input  logic [7:0]  replyData,
  output logic        replyReady,
  output logic        txStart,
  output logic [7:0]  txData,
  input  logic        txBusy,
  output logic [7:0]  kbDropCount,
  output logic [15:0] sentCount
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW   = $clog2(START_TIMEOUT + 1);

  TxSchedState_t state_q, state_d;
  TxSource_t     last_q, last_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          start_q, start_d;
  UartByte_t     data_q, data_d;
  logic [15:0]   sent_q, sent_d;
  logic [7:0]    drop_q, drop_d;

  UartByte_t     kb_rdata, reply_rdata;
  logic          kb_full, kb_empty, reply_full, reply_empty;
  logic          kb_pop, reply_pop, kb_drop;
  logic [CNTW-1:0] kb_count, reply_count;
  logic          unused_counts;

  assign unused_counts = ^{kb_count, reply_count};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_kb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (kbValid),
    .wdata_i (kbData),
    .pop_i   (kb_pop),
    .rdata_o (kb_rdata),
    .full_o  (kb_full),
    .empty_o (kb_empty),
    .count_o (kb_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_reply_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (replyValid && replyReady),
    .wdata_i (replyData),
    .pop_i   (reply_pop),
    .rdata_o (reply_rdata),
    .full_o  (reply_full),
    .empty_o (reply_empty),
    .count_o (reply_count)
  );

  assign replyReady  = !reply_full;
  assign kb_drop     = kbValid && kb_full && !kb_pop;
  assign txStart     = start_q;
  assign txData      = data_q;
  assign kbDropCount = drop_q;
  assign sentCount   = sent_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    start_d   = 1'b0;
    data_d    = data_q;
    sent_d    = sent_q;
    kb_pop    = 1'b0;
    reply_pop = 1'b0;
    drop_d    = (kb_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    case (state_q)
      IDLE: begin
        // Never start while the transmitter is still shifting, e.g. after a mid-frame reset.
        if (!txBusy && (!kb_empty || !reply_empty)) begin
          if (!kb_empty && (reply_empty || last_q == REPLY)) begin
            kb_pop = 1'b1;
            data_d = kb_rdata;
            last_d = KEYBOARD;
          end else begin
            reply_pop = 1'b1;
            data_d    = reply_rdata;
            last_d    = REPLY;
          end
          start_d = 1'b1;
          sent_d  = sent_q + 16'd1;
          state_d = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A transmitter that never showed busy is assumed to have finished already.
        if (txBusy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!txBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REPLY;
      tmo_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      sent_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      start_q <= start_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
    end
  end

endmodule
